// File: rtl/efuse_word_capture_pkg.sv
// ---------------------------------------------------------------------------
// efuse_pkg
//   Shared definitions for the eFuse word capture block:
//     - EFUSE_WIDTH : width of the eFuse macro parallel output (Q)
//     - EFUSE_MODE_*: mode encodings shared with efuses_control_sm
//     - efuse_state_e: capture FSM state encoding
// ---------------------------------------------------------------------------
package efuse_pkg;

  localparam int EFUSE_WIDTH = 32;

  localparam logic [1:0] EFUSE_MODE_IDLE = 2'b00;
  localparam logic [1:0] EFUSE_MODE_PROG = 2'b01;
  localparam logic [1:0] EFUSE_MODE_READ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } efuse_state_e;

endpackage

// File: rtl/efuse_word_capture_sync2.sv
// ---------------------------------------------------------------------------
// efuse_sync2
//   WIDTH-wide two-flop synchroniser for signals asynchronous to clk.
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset (both stages clear to 0)
//     d     : asynchronous input bus
//     q     : synchronised output bus (two clk cycles of latency)
// ---------------------------------------------------------------------------
module efuse_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/efuse_word_capture.sv
// ---------------------------------------------------------------------------
// efuse_word_capture
//   Captures the eFuse macro parallel output after a read. Q is synchronised,
//   allowed to settle, then sampled NSAMP times SPACING cycles apart; the word
//   is only accepted if every sample is identical. An accepted word is
//   compared against the programmed word to flag a bad burn.
//   Ports:
//     clk           : 2 MHz clock
//     rst           : asynchronous active-low reset
//     mode          : 2'b10 read, 2'b01 program, others idle
//     capture_req   : one-cycle pulse, Q may now be captured
//     Q             : eFuse macro output (asynchronous)
//     prog          : programmed word for the burn check
//     busy          : capture in progress
//     done          : one-cycle pulse when a capture completes or aborts
//     fuse_word     : last stable captured word
//     fuse_valid    : fuse_word holds a stable capture
//     fuse_unstable : last capture saw differing samples
//     prog_mismatch : stable capture differs from prog
//     aborted       : last capture was cut short by a mode change
// ---------------------------------------------------------------------------
module efuse_word_capture
  import efuse_pkg::*;
#(
  parameter int SETTLE  = 8,
  parameter int NSAMP   = 4,
  parameter int SPACING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   capture_req,
  input  logic [EFUSE_WIDTH-1:0] Q,
  input  logic [EFUSE_WIDTH-1:0] prog,
  output logic                   busy,
  output logic                   done,
  output logic [EFUSE_WIDTH-1:0] fuse_word,
  output logic                   fuse_valid,
  output logic                   fuse_unstable,
  output logic                   prog_mismatch,
  output logic                   aborted
);

  // One wait counter serves both the settle and the spacing intervals.
  localparam int WAIT_MAX = (SETTLE > SPACING) ? SETTLE : SPACING;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int NS_W     = $clog2(NSAMP + 1);

  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;
  localparam logic [NS_W-1:0]   NS_ONE   = 1;

  efuse_state_e           state;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [NS_W-1:0]        nsamp_cnt;
  logic                   diff;
  logic [EFUSE_WIDTH-1:0] ref_word;
  logic [EFUSE_WIDTH-1:0] q_s;

  logic is_read;
  logic settle_hit;
  logic space_hit;
  logic last_sample;

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_ONE;
  endfunction

  function automatic logic [NS_W-1:0] nsamp_inc(input logic [NS_W-1:0] v);
    return (&v) ? v : v + NS_ONE;
  endfunction

  efuse_sync2 #(
    .WIDTH (EFUSE_WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (Q),
    .q     (q_s)
  );

  assign is_read     = (mode == EFUSE_MODE_READ);
  assign settle_hit  = (int'(wait_cnt) == SETTLE - 1);
  assign space_hit   = (int'(wait_cnt) == SPACING - 1);
  assign last_sample = (int'(nsamp_cnt) + 1 == NSAMP);

  // Reference sample is pure data: taken once at the end of the settle wait.
  always_ff @(posedge clk) begin
    if (state == ST_SETTLE && is_read && settle_hit) begin
      ref_word <= q_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      nsamp_cnt     <= '0;
      diff          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fuse_word     <= '0;
      fuse_valid    <= 1'b0;
      fuse_unstable <= 1'b0;
      prog_mismatch <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture_req && is_read) begin
            state         <= ST_SETTLE;
            busy          <= 1'b1;
            wait_cnt      <= '0;
            nsamp_cnt     <= '0;
            diff          <= 1'b0;
            fuse_valid    <= 1'b0;
            fuse_unstable <= 1'b0;
            prog_mismatch <= 1'b0;
            aborted       <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (!is_read) begin
            state   <= ST_DONE;
            aborted <= 1'b1;
          end else if (settle_hit) begin
            state     <= ST_SAMPLE;
            wait_cnt  <= '0;
            nsamp_cnt <= NS_ONE;
          end else begin
            wait_cnt <= wait_inc(wait_cnt);
          end
        end

        ST_SAMPLE: begin
          // Abort is checked first so it wins over a coincident last sample.
          if (!is_read) begin
            state   <= ST_DONE;
            aborted <= 1'b1;
          end else if (space_hit) begin
            wait_cnt  <= '0;
            nsamp_cnt <= nsamp_inc(nsamp_cnt);
            if (q_s != ref_word) begin
              diff <= 1'b1;
            end
            if (last_sample) begin
              state <= ST_CHECK;
            end
          end else begin
            wait_cnt <= wait_inc(wait_cnt);
          end
        end

        ST_CHECK: begin
          if (!diff) begin
            fuse_word     <= ref_word;
            fuse_valid    <= 1'b1;
            prog_mismatch <= (ref_word != prog);
          end else begin
            fuse_unstable <= 1'b1;
          end
          state <= ST_DONE;
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_word_capture.sv
module tb_efuse_word_capture;
  import efuse_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode;
  logic        capture_req;
  logic [31:0] Q;
  logic [31:0] prog;
  logic        busy;
  logic        done;
  logic [31:0] fuse_word;
  logic        fuse_valid;
  logic        fuse_unstable;
  logic        prog_mismatch;
  logic        aborted;

  efuse_word_capture dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .capture_req   (capture_req),
    .Q             (Q),
    .prog          (prog),
    .busy          (busy),
    .done          (done),
    .fuse_word     (fuse_word),
    .fuse_valid    (fuse_valid),
    .fuse_unstable (fuse_unstable),
    .prog_mismatch (prog_mismatch),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] q;
    logic [31:0] prog;
    logic        flip3;
    logic [31:0] exp_word;
    logic        exp_valid;
    logic        exp_mm;
    logic        exp_unst;
  } vec_t;

  vec_t vecs[5];

  // Starts a capture and counts negedges after the accepting edge until done.
  // abort_at: cycle at which mode is switched to program (0 = never).
  // extra_req: cycle at which a second capture_req is pulsed while busy.
  task automatic run_capture(input logic [31:0] q_in, input logic [31:0] p_in,
                             input logic flip3, input int abort_at,
                             input int extra_req, output int lat);
    int extra_done;
    @(negedge clk);
    Q = q_in;
    prog = p_in;
    mode = EFUSE_MODE_READ;
    capture_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    capture_req = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) check1("busy_after_accept", busy, 1'b1);
      if (done) begin
        lat = c;
        break;
      end
      capture_req = (c == extra_req);
      if (flip3 && c == 10) Q = Q ^ 32'h0000_0008;
      if (c == abort_at) mode = EFUSE_MODE_PROG;
    end
    capture_req = 1'b0;
    if (lat < 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    check1("busy_at_done", busy, 1'b0);
    extra_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check_int("extra_done", extra_done, 0);
  endtask

  initial begin
    int lat;
    int busy_seen;
    int done_seen;

    mode = EFUSE_MODE_IDLE;
    capture_req = 1'b0;
    Q = '0;
    prog = '0;

    vecs[0] = '{32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'hA5A55A5B, 32'hA5A55A5A, 1'b0, 32'hA5A55A5B, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'hA5A55A5B, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check32("reset_word", fuse_word, 32'h0);
    check32("reset_flags",
            {26'h0, busy, done, fuse_valid, fuse_unstable, prog_mismatch, aborted}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_capture(vecs[i].q, vecs[i].prog, vecs[i].flip3, 0, 5, lat);
      check_int($sformatf("v%0d_latency", i), lat, 16);
      check32($sformatf("v%0d_word", i), fuse_word, vecs[i].exp_word);
      check1($sformatf("v%0d_valid", i), fuse_valid, vecs[i].exp_valid);
      check1($sformatf("v%0d_mismatch", i), prog_mismatch, vecs[i].exp_mm);
      check1($sformatf("v%0d_unstable", i), fuse_unstable, vecs[i].exp_unst);
      check1($sformatf("v%0d_aborted", i), aborted, 1'b0);
    end

    // Abort during SETTLE, with a second request while busy.
    run_capture(32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 3, 2, lat);
    check_int("abort_settle_latency", lat, 5);
    check1("abort_settle_aborted", aborted, 1'b1);
    check1("abort_settle_valid", fuse_valid, 1'b0);
    check1("abort_settle_mismatch", prog_mismatch, 1'b0);
    check32("abort_settle_word", fuse_word, 32'hFFFFFFFF);

    // Mode change coincident with the last sample: abort wins.
    run_capture(32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 13, 0, lat);
    check_int("abort_last_latency", lat, 15);
    check1("abort_last_aborted", aborted, 1'b1);
    check1("abort_last_valid", fuse_valid, 1'b0);
    check1("abort_last_unstable", fuse_unstable, 1'b0);

    // Request in program mode is ignored.
    @(negedge clk);
    mode = EFUSE_MODE_PROG;
    capture_req = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
      @(negedge clk);
    end
    check_int("prog_mode_busy", busy_seen, 0);
    check_int("prog_mode_done", done_seen, 0);

    // Reset mid-SAMPLE clears everything at once.
    @(negedge clk);
    Q = 32'hA5A55A5A;
    prog = 32'hA5A55A5A;
    mode = EFUSE_MODE_READ;
    capture_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    capture_req = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    check32("midreset_word", fuse_word, 32'h0);
    check32("midreset_flags",
            {26'h0, busy, done, fuse_valid, fuse_unstable, prog_mismatch, aborted}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_capture(32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 0, 0, lat);
    check_int("post_reset_latency", lat, 16);
    check32("post_reset_word", fuse_word, 32'hA5A55A5A);
    check1("post_reset_valid", fuse_valid, 1'b1);
    check1("post_reset_mismatch", prog_mismatch, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
